// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use bubbles, multi-cycle mul/div
// freeze, taken-branch flush, plus saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_muldiv,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned MD_CLOG = $clog2(MD_CYCLES);
  localparam int unsigned MD_W    = (MD_CLOG > 3) ? MD_CLOG : 3;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [MD_W-1:0]   r_md_cnt;
  logic [MD_W-1:0]   w_md_cnt_nxt;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_count;
  logic              w_load_use;

  // Load in EX whose destination feeds a source the ID instruction really reads
  assign w_load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == id_ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == id_ex_rd)));

  // Next state and zero-latency control outputs; reset forces the no-hazard defaults
  always_comb begin
    w_state_nxt   = r_state;
    w_md_cnt_nxt  = r_md_cnt;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    md_busy       = 1'b0;
    if (rst_n) begin
      case (r_state)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (id_ex_muldiv) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            md_busy       = 1'b1;
            w_md_cnt_nxt  = MD_W'(MD_CYCLES - 2);
            w_state_nxt   = MD_WAIT;
          end else if (w_load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          if (r_md_cnt != '0) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            md_busy       = 1'b1;
            w_md_cnt_nxt  = r_md_cnt - MD_W'(1);
          end else begin
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // State, mul/div countdown and saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_md_cnt       <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (!pc_write && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (if_id_flush && (r_flush_count != {CNT_W{1'b1}}))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues hand-computed expectations,
// a negedge monitor pops and compares against the live outputs.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  // Control vector: {pc_write, if_id_write, id_ex_write, id_ex_bubble,
  //                  ex_mem_bubble, if_id_flush, id_ex_flush, md_busy}
  localparam logic [7:0] C_DEF = 8'b1110_0000;
  localparam logic [7:0] C_LU  = 8'b0011_0000;
  localparam logic [7:0] C_BR  = 8'b1110_0110;
  localparam logic [7:0] C_MD  = 8'b0000_1001;

  typedef struct {
    logic [7:0]       ctrl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    string            name;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, id_ex_rd;
  logic             id_use_rs1, id_use_rs2, id_ex_memread, id_ex_muldiv, ex_branch_taken;
  logic             pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble;
  logic             if_id_flush, id_ex_flush, md_busy;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [7:0]       w_ctrl;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  hazard_ctrl #(.MD_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .id_ex_muldiv(id_ex_muldiv), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .md_busy(md_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign w_ctrl = {pc_write, if_id_write, id_ex_write, id_ex_bubble,
                   ex_mem_bubble, if_id_flush, id_ex_flush, md_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (w_ctrl !== e.ctrl) begin
        failed++;
        $display("FAIL %s ctrl: got %b expected %b", e.name, w_ctrl, e.ctrl);
      end
      tests++;
      if (stall_cycles !== e.stall || flush_count !== e.flush) begin
        failed++;
        $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, stall_cycles, flush_count, e.stall, e.flush);
      end
    end
  end

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                      input logic md, input logic br, input logic [7:0] ctrl,
                      input int stall, input int flush, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rst;
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_use_rs1      = u1;
    id_use_rs2      = u2;
    id_ex_memread   = mr;
    id_ex_rd        = rd;
    id_ex_muldiv    = md;
    ex_branch_taken = br;
    e.ctrl  = ctrl;
    e.stall = CNT_W'(stall);
    e.flush = CNT_W'(flush);
    e.name  = name;
    q.push_back(e);
  endtask

  task automatic idle(input int stall, input int flush, input string name);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_DEF, stall, flush, name);
  endtask

  initial begin
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_ex_memread = 1'b0; id_ex_rd = '0; id_ex_muldiv = 1'b0; ex_branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    // Reset forces defaults even with a hazard on the inputs
    step(1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_DEF, 0, 0, "reset_defaults");
    step(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_LU,  0, 0, "load_use_rs2");
    idle(1, 0, "after_load_use");
    step(1'b1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_DEF, 1, 0, "load_x0");
    step(1'b1, 5'd7, 5'd3, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, C_DEF, 1, 0, "rs1_unused");
    step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, C_BR,  1, 0, "branch_over_lu");
    idle(1, 1, "after_branch");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, C_BR,  1, 1, "branch_over_md");
    idle(1, 2, "after_branch_md");

    // Mul/div held four cycles: three freeze cycles then release
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_MD,  1, 2, "md_start");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_MD,  2, 2, "md_wait1");
    step(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, C_MD,  3, 2, "md_wait2_ignore");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_DEF, 4, 2, "md_release");
    idle(4, 2, "after_md");

    // Reset during the second MD_WAIT cycle aborts the stall
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_MD,  4, 2, "md2_start");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_MD,  5, 2, "md2_wait1");
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_DEF, 6, 2, "md2_reset");
    idle(0, 0, "post_reset_run");

    // Twenty back-to-back load-use stalls saturate the 4-bit counter at 15
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, C_LU,
           (k > 15) ? 15 : k, 0, "lu_saturate");
    end
    idle(15, 0, "stall_saturated");

    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
